// File: rtl/uvma_mapu_b_arb_pkg.sv
// Shared types and sizing helpers for the MAPU block-input matrix arbiter.
`ifndef UVMA_MAPU_B_DATA_WIDTH_MAX
`define UVMA_MAPU_B_DATA_WIDTH_MAX 32
`endif

package uvma_mapu_b_arb_pkg;

   typedef enum logic {IDLE, XFER} uvma_mapu_b_arb_state_t;

   function automatic int beats(input int dim);
      return dim * dim;
   endfunction

   // A 1x1 matrix still needs a one-bit counter.
   function automatic int cnt_w(input int dim);
      return (dim * dim > 1) ? $clog2(dim * dim) : 1;
   endfunction

   localparam int MAPU_B_BEATS_DEF = beats(3);
   localparam int MAPU_B_CNT_W_DEF = $clog2(MAPU_B_BEATS_DEF);

endpackage

// File: rtl/uvma_mapu_b_rr_picker.sv
// Combinational round-robin find-first: lowest offset from last_i+1 (with wrap) wins.
module uvma_mapu_b_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic               any_o,
   output logic [IDX_W-1:0]   idx_o
);

   always_comb begin
      any_o = |req_i;
      idx_o = '0;
      // Walk from the farthest offset down so the nearest requester is written last.
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req_i[(int'(last_i) + k) % NUM_REQ])
            idx_o = IDX_W'((int'(last_i) + k) % NUM_REQ);
      end
   end

endmodule

// File: rtl/uvma_mapu_b_arb.sv
// Matrix-granular round-robin arbiter feeding the single MAPU block input stream.
module uvma_mapu_b_arb
   import uvma_mapu_b_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = `UVMA_MAPU_B_DATA_WIDTH_MAX,
   parameter int MATRIX_DIM = 3
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_vld,
   output logic [NUM_REQ-1:0]            req_rdy,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat,
   output logic                          o_vld,
   input  logic                          o_rdy,
   output logic [DATA_WIDTH-1:0]         o_dat,
   output logic                          o_sof,
   output logic                          o_eof,
   output logic [$clog2(NUM_REQ)-1:0]    o_src,
   output logic                          busy
);

   localparam int BEATS = beats(MATRIX_DIM);
   localparam int CNT_W = cnt_w(MATRIX_DIM);
   localparam int IDX_W = $clog2(NUM_REQ);

   uvma_mapu_b_arb_state_t state_q, state_d;
   logic [IDX_W-1:0]       gnt_q, gnt_d;
   logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
   logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic                   pick_any;
   logic [IDX_W-1:0]       pick_idx;

   uvma_mapu_b_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_i  (req_vld),
      .last_i (last_gnt_q),
      .any_o  (pick_any),
      .idx_o  (pick_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         last_gnt_q <= IDX_W'(NUM_REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      beat_cnt_d = beat_cnt_q;
      o_vld      = 1'b0;
      req_rdy    = '0;
      o_sof      = 1'b0;
      o_eof      = 1'b0;
      o_src      = '0;
      busy       = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_idx;
               state_d = XFER;
            end
         end
         XFER: begin
            busy           = 1'b1;
            o_src          = gnt_q;
            o_vld          = req_vld[gnt_q];
            req_rdy[gnt_q] = o_rdy;
            o_sof          = (beat_cnt_q == '0) && o_vld;
            o_eof          = (beat_cnt_q == CNT_W'(BEATS - 1)) && o_vld;
            if (o_vld && o_rdy) begin
               // Last beat releases the grant; the next pick starts after it.
               if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                  beat_cnt_d = '0;
                  last_gnt_d = gnt_q;
                  state_d    = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Zero when nothing is offered so the block input never sees stale data.
   assign o_dat = o_vld ? req_dat[gnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_uvma_mapu_b_arb.sv
// Randomized bench for uvma_mapu_b_arb with a matrix-level reference model.
module tb_uvma_mapu_b_arb;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int NB = 9;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [NR-1:0]       req_vld = '0;
   logic [NR-1:0]       req_rdy;
   logic [NR*DW-1:0]    req_dat = '0;
   logic                o_vld, o_rdy = 1'b0, o_sof, o_eof, busy;
   logic [DW-1:0]       o_dat;
   logic [1:0]          o_src;

   logic                rst2 = 1'b0;
   logic [1:0]          vld2 = 2'b00;
   logic [1:0]          rdy2;
   logic [15:0]         dat2 = 16'h1234;
   logic                ovld2, osof2, oeof2, busy2;
   logic [7:0]          odat2;
   logic [0:0]          osrc2;
   logic                done2 = 1'b0;

   always #5 clk = ~clk;

   uvma_mapu_b_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MATRIX_DIM(3)) dut (
      .clk(clk), .reset_n(reset_n), .req_vld(req_vld), .req_rdy(req_rdy), .req_dat(req_dat),
      .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_sof(o_sof), .o_eof(o_eof),
      .o_src(o_src), .busy(busy)
   );

   uvma_mapu_b_arb #(.NUM_REQ(2), .DATA_WIDTH(8), .MATRIX_DIM(2)) dut2 (
      .clk(clk), .reset_n(rst2), .req_vld(vld2), .req_rdy(rdy2), .req_dat(dat2),
      .o_vld(ovld2), .o_rdy(1'b1), .o_dat(odat2), .o_sof(osof2), .o_eof(oeof2),
      .o_src(osrc2), .busy(busy2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Matrix-level model: who holds the stream, and which beat each requester is on.
   typedef struct {int cyc; int src; int beat;} ent_t;
   ent_t           lg[$];
   int             owner, mlast, cyc, first_vld, first_ovld;
   int             bidx[NR], budget[NR], pct[NR], hold_off[NR];
   logic [DW-1:0]  mdat[NR][NB];
   int             rdy_mode;
   logic           rdy_t = 1'b0;
   bit             stall_en = 0;

   task automatic new_matrix(input int k);
      for (int j = 0; j < NB; j++) mdat[k][j] = DW'($urandom);
   endtask

   task automatic model_reset();
      owner = -1; mlast = NR - 1;
      for (int k = 0; k < NR; k++) begin
         bidx[k] = 0; budget[k] = 0; pct[k] = 100; hold_off[k] = 0; new_matrix(k);
      end
      rdy_mode = 0; stall_en = 0;
   endtask

   task automatic clr_log();
      lg.delete(); first_vld = -1; first_ovld = -1;
   endtask

   task automatic drive();
      for (int k = 0; k < NR; k++) begin
         if (hold_off[k] > 0) begin
            req_vld[k] = 1'b0; hold_off[k]--;
         end else begin
            req_vld[k] = (budget[k] > 0) && ($urandom_range(99) < pct[k]);
         end
         req_dat[k*DW +: DW] = mdat[k][bidx[k]];
      end
      rdy_t = ~rdy_t;
      case (rdy_mode)
         0: o_rdy = 1'b1;
         1: o_rdy = ($urandom_range(99) < 70);
         default: o_rdy = rdy_t;
      endcase
   endtask

   task automatic sample();
      int nxt_owner, nxt_last;
      logic [NR-1:0] er;
      nxt_owner = owner; nxt_last = mlast;
      if (first_vld < 0 && |req_vld) first_vld = cyc;
      if (first_ovld < 0 && o_vld) first_ovld = cyc;
      if (owner < 0) begin
         chk("idle_busy", busy, 0);
         chk("idle_vld", o_vld, 0);
         chk("idle_rdy", req_rdy, 0);
         chk("idle_sof_eof", {o_sof, o_eof}, 0);
         chk("idle_dat", o_dat, 0);
         for (int off = 1; off <= NR; off++) begin
            if (nxt_owner < 0 && req_vld[(mlast + off) % NR]) nxt_owner = (mlast + off) % NR;
         end
      end else begin
         er = '0;
         er[owner] = o_rdy;
         chk("busy", busy, 1);
         chk("src", o_src, owner);
         chk("vld", o_vld, req_vld[owner]);
         chk("req_rdy", req_rdy, er);
         chk("sof", o_sof, req_vld[owner] && bidx[owner] == 0);
         chk("eof", o_eof, req_vld[owner] && bidx[owner] == NB - 1);
         chk("dat", o_dat, req_vld[owner] ? mdat[owner][bidx[owner]] : '0);
         if (req_vld[owner] && o_rdy) begin
            lg.push_back('{cyc, owner, bidx[owner]});
            if (stall_en && owner == 1 && bidx[owner] == 4) begin
               hold_off[1] = 5; stall_en = 0;
            end
            bidx[owner]++;
            if (bidx[owner] == NB) begin
               bidx[owner] = 0; budget[owner]--; new_matrix(owner);
               nxt_owner = -1; nxt_last = owner;
            end
         end
      end
      owner = nxt_owner; mlast = nxt_last; cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run(input string tag, input int maxc);
      int  n;
      bit  done;
      drive();
      n = 0; done = 0;
      while (!done && n < maxc) begin
         done = (owner < 0);
         for (int k = 0; k < NR; k++) if (budget[k] > 0) done = 0;
         if (!done) begin step(); n++; end
      end
      chk({tag, "_done"}, done, 1);
   endtask

   task automatic check_rst_outs(input string tag);
      chk({tag, "_vld"}, o_vld, 0);
      chk({tag, "_rdy"}, req_rdy, 0);
      chk({tag, "_sof_eof"}, {o_sof, o_eof}, 0);
      chk({tag, "_src"}, o_src, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_vld = '0;
      #1;
      check_rst_outs("rst");
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      clr_log();
      reset_n = 1'b1;
   endtask

   function automatic int nth_sof_src(input int n);
      int c;
      c = 0;
      foreach (lg[i]) begin
         if (lg[i].beat == 0) begin
            if (c == n) return lg[i].src;
            c++;
         end
      end
      return -1;
   endfunction

   // Two-requester, 2x2 build: both always valid, sources must alternate from 0.
   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      rst2 = 1'b1; vld2 = 2'b11;
      n = 0;
      for (int c = 0; c < 80 && n < 6; c++) begin
         @(negedge clk);
         if (ovld2 && osof2) begin
            chk("nr2_src", osrc2, n % 2);
            n++;
         end
      end
      chk("nr2_count", n, 6);
      done2 = 1'b1;
   end

   initial begin
      int t0;
      cyc = 0;
      model_reset();
      clr_log();
      #1;
      check_rst_outs("por");

      // Single requester 2, one matrix at full rate.
      do_reset();
      budget[2] = 1;
      run("single", 100);
      chk("single_lat", first_ovld - first_vld, 1);
      chk("single_beats", lg.size(), NB);
      chk("single_span", lg[lg.size()-1].cyc - lg[0].cyc, NB - 1);

      // All four valid for eight matrices.
      do_reset();
      for (int k = 0; k < NR; k++) budget[k] = 2;
      run("fair", 200);
      for (int m = 0; m < 8; m++) chk($sformatf("fair_order%0d", m), nth_sof_src(m), m % NR);
      chk("fair_span", lg[lg.size()-1].cyc - first_vld + 1, 80);

      // Requester 1 stalls after beat 4 while requester 3 waits.
      do_reset();
      budget[1] = 1; budget[3] = 1; stall_en = 1;
      run("stall", 200);
      chk("stall_gap", lg[5].cyc - lg[4].cyc, 6);
      chk("stall_tail_src", lg[8].src, 1);
      chk("stall_next_src", lg[9].src, 3);

      // o_rdy toggling every cycle.
      do_reset();
      budget[2] = 1; rdy_mode = 2;
      run("toggle", 200);
      chk("toggle_beats", lg.size(), NB);
      chk("toggle_span", lg[lg.size()-1].cyc - lg[0].cyc, 2 * (NB - 1));

      // Reset in the middle of a matrix from requester 0.
      do_reset();
      budget[0] = 1;
      drive();
      t0 = 0;
      while (bidx[0] != 5 && t0 < 50) begin step(); t0++; end
      chk("midrst_reach", bidx[0], 5);
      reset_n = 1'b0;
      #1;
      check_rst_outs("midrst");
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      clr_log();
      reset_n = 1'b1;
      budget[0] = 1; budget[1] = 1;
      run("midrst_after", 200);
      chk("midrst_first", nth_sof_src(0), 0);
      chk("midrst_second", nth_sof_src(1), 1);

      // Random traffic and back-pressure, grant history carried across rounds.
      do_reset();
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NR; k++) begin
            budget[k] = $urandom_range(3);
            pct[k]    = $urandom_range(100, 30);
         end
         rdy_mode = 1;
         run($sformatf("rnd%0d", r), 3000);
      end

      for (int c = 0; c < 200 && !done2; c++) @(posedge clk);
      chk("nr2_finished", done2, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
